vga_timing_rx: RTL and testbench
================================

# vga_timing_rx

Receive-side counterpart of the 640×480@60 Hz VGA timing generator. It samples the `hys`/`vys`/`lcd_rgb` stream in the 25 MHz pixel clock domain and recovers pixel coordinates and a data-enable. It checks line and frame lengths against nominal timing and declares lock. It also counts active pixels that differ from an expected colour. It sits on the loopback/self-test path next to the generator and drives status LEDs or a debug UART.

## Interface
- `H_TOTAL`, 800: clocks per line.
- `H_START`, 144: first active sample, counted from the hsync falling edge (sync 96 + back porch 48).
- `H_ACT`, 640: active pixels per line.
- `V_TOTAL`, 525: lines per frame.
- `V_START`, 35: first active line (sync 2 + back porch 33).
- `V_ACT`, 480: active lines.
- `LOCK_FRAMES`, 2: consecutive good frames required to lock (1..15).
- `EXP_RGB`, 16'hF800: expected active-pixel colour, RGB565.
- `clk` in 1: pixel clock, 25 MHz; the only clock.
- `rst` in 1: reset is synchronous and active-high.
- `hys` in 1: horizontal sync, active-low pulse.
- `vys` in 1: vertical sync, active-low pulse.
- `lcd_rgb` in 16: pixel data, RGB565.
- `pix_de` out 1: active-area data enable, gated by lock.
- `pix_x` out 10: column in the active area.
- `pix_y` out 10: row in the active area.
- `pix_rgb` out 16: captured pixel; 0 when `pix_de` is low.
- `frame_start` out 1: one-cycle pulse at each recovered frame start.
- `locked` out 1: timing lock status.
- `err_cnt` out 8: timing errors counted while locked; saturates at 255.
- `mis_cnt` out 16: active pixels not equal to `EXP_RGB` while locked; saturates at 65535.

## Operation
- Input stage: `hys`, `vys`, `lcd_rgb` registered once (s1), then `hys`/`vys` registered again (s2).
  - Falling edge = s2 high and s1 low.
  - The inputs come from the same clock domain, so there is no synchronizer.
- `h_pos` (11 bit): set to 0 on the cycle the s1 sample shows the hsync falling edge, otherwise +1. Saturates at 2047.
- Frame-start flag: set by a vsync falling edge, cleared at the next hsync falling edge. A vsync fall on the same cycle as the hsync fall counts.
- `v_pos` (10 bit), updated at each hsync falling edge:
  - set to 0 if the frame-start flag is set;
  - otherwise +1, saturating at 1023.
  - `frame_start` pulses in that same cycle.
- Line error: an hsync falling edge where the previous `h_pos` ≠ `H_TOTAL`−1. Also raised when `h_pos` reaches 2047 (sync lost), once per saturation.
  - Not raised for the first hsync edge after reset or after entering SEARCH.
- Frame error: at frame start, the previous `v_pos` ≠ `V_TOTAL`−1. Also raised when `v_pos` reaches 1023.
  - Not raised for the first frame start after SEARCH.
- Lock FSM, states SEARCH / CHECK / LOCKED. Reset state is SEARCH with `good_cnt` = 0.
  - SEARCH: at the first frame start → CHECK, `good_cnt` = 0.
  - CHECK, on any line or frame error: `good_cnt` = 0, stay in CHECK.
  - CHECK, at a frame start with no error since the previous frame start: `good_cnt`+1. When it reaches `LOCK_FRAMES` → LOCKED.
  - LOCKED, on any error: → SEARCH and `err_cnt`+1 (saturating).
  - Error and frame start in the same cycle: the error takes priority.
- Active area: `h_pos` in [`H_START`, `H_START`+`H_ACT`) and `v_pos` in [`V_START`, `V_START`+`V_ACT`).
  - `pix_x` = `h_pos`−`H_START`; `pix_y` = `v_pos`−`V_START`.
  - `pix_de` = active area AND LOCKED.
- Pixel check: when `pix_de` is high and the s1 `lcd_rgb` ≠ `EXP_RGB`, `mis_cnt`+1 (saturating).
- `err_cnt` and `mis_cnt` clear only on `rst`.

## Timing
- All outputs are registered.
- Latency: an input sample launched at edge N appears on `pix_*` after edge N+2.
- `frame_start` and the `locked` rise align with that same 2-cycle pipeline.
- `locked` falls on the cycle after the error is detected. Any in-progress `pix_de` drops on that same cycle.
- Reset values: all outputs 0; FSM in SEARCH; `h_pos` = 2047 (no error raised for this value); `v_pos` = 0.
- `rst` asserted mid-frame: on the next edge all state and counters clear and `locked` falls. Reacquisition then needs 1 + `LOCK_FRAMES` frame starts.
- `pix_x`/`pix_y` hold their last value while `pix_de` is low.

## Test plan
- Nominal 800×525 stream, all active pixels `EXP_RGB`, `LOCK_FRAMES`=2 → `locked` rises at the 3rd `frame_start`. `mis_cnt` stays 0. `pix_de` is high exactly 640×480 cycles per frame. The first DE pixel has `pix_x`=0, `pix_y`=0, and `pix_x` reaches 639 on the last pixel of each line.
- Locked stream, one line shortened to 799 clocks → `locked` falls 1 cycle after that hsync edge. `err_cnt`=1. Relock after 3 more frame starts.
- Locked stream, 10 active pixels set to 16'h07E0 → `mis_cnt`=10. `pix_rgb` shows 16'h07E0 at those coordinates with 2-cycle latency.
- `hys` held high for 3000 clocks while locked → error when `h_pos` hits 2047, `locked`=0, `err_cnt`+1 exactly once.
- Frame with 524 lines during CHECK → `good_cnt` resets. `locked` is delayed by one frame; `err_cnt` unchanged.
- `rst` pulsed for 1 cycle mid-active-line while locked → next cycle all outputs 0 and counters 0. Relock after 3 frame starts.

Source files
------------

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates and data-enable from a VGA
// hys/vys/lcd_rgb stream, checks line/frame lengths, declares lock and
// counts timing errors and off-colour active pixels.
//   clk, rst        : pixel clock, synchronous active-high reset
//   hys, vys        : active-low sync pulses (same clock domain)
//   lcd_rgb         : RGB565 pixel data
//   pix_de/x/y/rgb  : recovered active-area pixel, valid while locked
//   frame_start     : one-cycle pulse per recovered frame start
//   locked          : timing lock status
//   err_cnt/mis_cnt : saturating timing-error / pixel-mismatch counters
module vga_timing_rx #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic [15:0] EXP_RGB     = 16'hF800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hys,
  input  logic        vys,
  input  logic [15:0] lcd_rgb,
  output logic        pix_de,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [15:0] mis_cnt
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned GW = 4;
  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_good, w_good_nxt;
  logic            r_bad, w_bad_nxt;
  logic            w_err_inc;

  logic            r_hys1, r_hys2, r_vys1, r_vys2;
  logic [15:0]     r_rgb1;
  logic [HW-1:0]   r_h_pos, w_h_nxt;
  logic [VW-1:0]   r_v_pos, w_v_nxt;
  logic            r_vflag, r_skip_h;

  logic            w_hfall, w_vfall, w_vflag, w_fs;
  logic            w_line_err, w_frame_err, w_err, w_de;

  // Edge detection on the two-stage sync samples
  assign w_hfall = r_hys2 & ~r_hys1;
  assign w_vfall = r_vys2 & ~r_vys1;
  // A vsync fall coinciding with the hsync fall still marks this line as frame start
  assign w_vflag = r_vflag | w_vfall;
  assign w_fs    = w_hfall & w_vflag;

  // Position counters (next values; both the counters and outputs use these)
  always_comb begin
    w_h_nxt = r_h_pos;
    w_v_nxt = r_v_pos;
    if (w_hfall)                w_h_nxt = '0;
    else if (r_h_pos != H_MAX)  w_h_nxt = r_h_pos + HW'(1);
    if (w_hfall) begin
      if (w_vflag)              w_v_nxt = '0;
      else if (r_v_pos != V_MAX) w_v_nxt = r_v_pos + VW'(1);
    end
  end

  // Saturation errors fire only on the step into the saturated value
  assign w_line_err  = (w_hfall & ~r_skip_h & (r_h_pos != HW'(H_TOTAL - 1))) |
                       (~w_hfall & (r_h_pos == H_MAX - HW'(1)));
  assign w_frame_err = w_hfall & ((w_vflag & (r_v_pos != VW'(V_TOTAL - 1))) |
                                  (~w_vflag & (r_v_pos == V_MAX - VW'(1))));
  assign w_err       = w_line_err | w_frame_err;

  // Lock FSM next-state; errors win over a coincident frame start
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_err_inc   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_fs) begin
          w_state_nxt = CHECK;
          w_good_nxt  = '0;
          w_bad_nxt   = 1'b0;
        end
      end
      CHECK: begin
        if (w_err) begin
          w_good_nxt = '0;
          // an error at frame start closes that frame; otherwise taint the current one
          w_bad_nxt  = ~w_fs;
        end else if (w_fs) begin
          w_bad_nxt = 1'b0;
          if (!r_bad) begin
            w_good_nxt = r_good + GW'(1);
            if (r_good + GW'(1) >= GW'(LOCK_FRAMES)) w_state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (w_err) begin
          w_state_nxt = SEARCH;
          w_good_nxt  = '0;
          w_err_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_good_nxt  = '0;
      end
    endcase
  end

  assign w_de = (w_h_nxt >= HW'(H_START)) && (w_h_nxt < HW'(H_START + H_ACT)) &&
                (w_v_nxt >= VW'(V_START)) && (w_v_nxt < VW'(V_START + V_ACT)) &&
                (w_state_nxt == LOCKED);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_good      <= '0;
      r_bad       <= 1'b0;
      r_hys1      <= 1'b0;
      r_hys2      <= 1'b0;
      r_vys1      <= 1'b0;
      r_vys2      <= 1'b0;
      r_rgb1      <= '0;
      r_h_pos     <= H_MAX;
      r_v_pos     <= '0;
      r_vflag     <= 1'b0;
      r_skip_h    <= 1'b1;
      pix_de      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_cnt     <= '0;
      mis_cnt     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      r_bad       <= w_bad_nxt;
      r_hys1      <= hys;
      r_hys2      <= r_hys1;
      r_vys1      <= vys;
      r_vys2      <= r_vys1;
      r_rgb1      <= lcd_rgb;
      r_h_pos     <= w_h_nxt;
      r_v_pos     <= w_v_nxt;
      r_vflag     <= w_hfall ? 1'b0 : w_vflag;
      // the first hsync edge after (re)entering SEARCH has no valid previous line
      if (w_state_nxt == SEARCH && r_state != SEARCH) r_skip_h <= 1'b1;
      else if (w_hfall)                               r_skip_h <= 1'b0;
      pix_de      <= w_de;
      pix_rgb     <= w_de ? r_rgb1 : 16'h0000;
      if (w_de) begin
        pix_x <= 10'(w_h_nxt - HW'(H_START));
        pix_y <= 10'(w_v_nxt - VW'(V_START));
      end
      frame_start <= w_fs;
      locked      <= (w_state_nxt == LOCKED);
      if (w_err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (w_de && r_rgb1 != EXP_RGB && mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Testbench for vga_timing_rx on a reduced 40x30 raster so whole frames stay short.
module tb_vga_timing_rx;

  localparam int HT = 40, HS = 12, HA = 20;
  localparam int VT = 30, VS = 5,  VA = 20;
  localparam logic [15:0] EXP = 16'hF800;
  localparam logic [15:0] BAD = 16'h07E0;

  logic        clk = 1'b0;
  logic        rst, hys, vys;
  logic [15:0] lcd_rgb;
  logic        pix_de, frame_start, locked;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_rgb, mis_cnt;
  logic [7:0]  err_cnt;

  vga_timing_rx #(
    .H_TOTAL(HT), .H_START(HS), .H_ACT(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACT(VA),
    .LOCK_FRAMES(2), .EXP_RGB(EXP)
  ) dut (
    .clk(clk), .rst(rst), .hys(hys), .vys(vys), .lcd_rgb(lcd_rgb),
    .pix_de(pix_de), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked),
    .err_cnt(err_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rgb;
  } pix_t;

  pix_t sb_q[$];
  pix_t mon_e;
  int   n_chk = 0, n_pass = 0, de_cnt = 0, fs_cnt = 0;
  bit   lk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: pops the scoreboard on every DE output, counts DE cycles and frame starts
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (pix_de) begin
      de_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_de", 64'(pix_de), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pixel{x,y,rgb}", 64'({pix_x, pix_y, pix_rgb}), 64'(mon_e));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_de"},      64'(pix_de), 64'd0);
    check({tag, "_x"},       64'(pix_x), 64'd0);
    check({tag, "_y"},       64'(pix_y), 64'd0);
    check({tag, "_rgb"},     64'(pix_rgb), 64'd0);
    check({tag, "_fs"},      64'(frame_start), 64'd0);
    check({tag, "_locked"},  64'(locked), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_mis_cnt"}, 64'(mis_cnt), 64'd0);
  endtask

  // One frame of raster; optional shortened line, idle gap, mid-line reset, bad pixels
  task automatic send_frame(input int nl, input bit lk_start, input bit lk_fs,
                            input int short_l, input int idle_l, input int rst_l,
                            input bit mis_en, input logic [15:0] col,
                            input int exp_de, input string tag);
    int len;
    bit act;
    logic [15:0] px;
    lk = lk_start;
    for (int l = 0; l < nl; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        @(posedge clk); #1;
        if (l == 0 && p == 0) de_cnt = 0;
        rst = (l == rst_l && p == 15);
        if (l == rst_l && p == 15) lk = 0;
        if (l == rst_l && p == 16) begin
          chk_reset_outputs({tag, "_midrst"});
          sb_q.delete();
        end
        if (l == 0 && p == 2) begin
          check({tag, "_frame_start"}, 64'(frame_start), 64'd1);
          check({tag, "_locked_at_fs"}, 64'(locked), 64'(lk_fs));
        end
        if (short_l >= 0 && l == short_l + 1 && p == 1)
          check({tag, "_locked_before_drop"}, 64'(locked), 64'd1);
        if (short_l >= 0 && l == short_l + 1 && p == 2)
          check({tag, "_locked_after_drop"}, 64'(locked), 64'd0);
        hys = (p >= 4);
        vys = (l >= 2);
        act = (p >= HS) && (p < HS + HA) && (l >= VS) && (l < VS + VA);
        px  = (mis_en && l >= 6 && l < 16 && p == 12 + 2 * (l - 6)) ? BAD : col;
        lcd_rgb = act ? px : 16'h0000;
        if (act && lk) sb_q.push_back({10'(p - HS), 10'(l - VS), px});
      end
      if (l == short_l) lk = 0;
      if (l == idle_l) begin
        lk = 0;
        repeat (3000) begin
          @(posedge clk); #1;
          hys = 1'b1; vys = 1'b1; lcd_rgb = 16'h0000;
        end
      end
    end
    if (exp_de >= 0) check({tag, "_de_count"}, 64'(de_cnt), 64'(exp_de));
  endtask

  initial begin
    rst = 1'b1; hys = 1'b1; vys = 1'b1; lcd_rgb = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Acquisition: off-colour pixels while unlocked must not count
    send_frame(VT, 0, 0, -1, -1, -1, 0, 16'h001F, -1, "f1");
    send_frame(VT, 0, 0, -1, -1, -1, 0, EXP, -1, "f2");
    send_frame(VT, 1, 1, -1, -1, -1, 0, EXP, HA * VA, "f3");
    check("mis_after_lock", 64'(mis_cnt), 64'd0);

    // Ten mismatching pixels
    send_frame(VT, 1, 1, -1, -1, -1, 1, EXP, HA * VA, "f4");
    check("mis_ten", 64'(mis_cnt), 64'd10);

    // Shortened line 10 breaks lock
    send_frame(VT, 1, 1, 10, -1, -1, 0, EXP, 6 * HA, "f5");
    check("err_short_line", 64'(err_cnt), 64'd1);
    check("unlocked_short_line", 64'(locked), 64'd0);
    send_frame(VT, 0, 0, -1, -1, -1, 0, EXP, -1, "f6");
    send_frame(VT, 0, 0, -1, -1, -1, 0, EXP, -1, "f7");
    send_frame(VT, 1, 1, -1, -1, -1, 0, EXP, HA * VA, "f8");

    // hsync stuck high: h_pos saturation error once
    send_frame(VT, 1, 1, -1, 9, -1, 0, EXP, 5 * HA, "f9");
    check("err_hsat", 64'(err_cnt), 64'd2);
    check("unlocked_hsat", 64'(locked), 64'd0);
    check("mis_held", 64'(mis_cnt), 64'd10);

    // Short frame during CHECK delays lock by one frame
    send_frame(VT,     0, 0, -1, -1, -1, 0, EXP, -1, "f10");
    send_frame(VT - 1, 0, 0, -1, -1, -1, 0, EXP, -1, "f11");
    send_frame(VT,     0, 0, -1, -1, -1, 0, EXP, -1, "f12");
    send_frame(VT,     0, 0, -1, -1, -1, 0, EXP, -1, "f13");
    check("err_unchanged_check", 64'(err_cnt), 64'd2);

    // Reset pulse mid-active-line while locked
    send_frame(VT, 1, 1, -1, -1, 15, 0, EXP, 10 * HA + 2, "f14");
    send_frame(VT, 0, 0, -1, -1, -1, 0, EXP, -1, "f15");
    send_frame(VT, 0, 0, -1, -1, -1, 0, EXP, -1, "f16");
    send_frame(VT, 1, 1, -1, -1, -1, 0, EXP, HA * VA, "f17");

    repeat (4) @(posedge clk);
    #1;
    check("final_locked", 64'(locked), 64'd1);
    check("final_err", 64'(err_cnt), 64'd0);
    check("final_mis", 64'(mis_cnt), 64'd0);
    check("frame_start_total", 64'(fs_cnt), 64'd17);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
